// File: rtl/alu_pkg.sv
// Shared opcode map, FSM encoding and legality check for the sequential ALU
// and the harness checker.
package alu_pkg;

  localparam logic [31:0] OP_ADD = 32'd0;
  localparam logic [31:0] OP_SUB = 32'd1;
  localparam logic [31:0] OP_AND = 32'd2;
  localparam logic [31:0] OP_OR  = 32'd3;
  localparam logic [31:0] OP_XOR = 32'd4;
  localparam logic [31:0] OP_MUL = 32'd5;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GET_B   = 2'd1;
  localparam logic [1:0] ST_MUL_RUN = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  // Opcodes arrive zero-extended, so any set bit above bit 2 lands outside the legal range.
  function automatic logic is_legal_op(input logic [31:0] op, input logic mul_en);
    return (op <= OP_XOR) || (mul_en && (op == OP_MUL));
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one partial product per cycle for
// DATA_WIDTH cycles after start.
module alu_mul_seq #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [DATA_WIDTH-1:0]     a,
  input  logic [DATA_WIDTH-1:0]     b,
  output logic                      busy,
  output logic                      last_step,
  output logic [2*DATA_WIDTH-1:0]   product
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(DATA_WIDTH);

  logic [CW-1:0]             cnt_q, cnt_d;
  logic [2*DATA_WIDTH-1:0]   acc_q, acc_d;
  logic [2*DATA_WIDTH-1:0]   mcand_q, mcand_d;
  logic [DATA_WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*DATA_WIDTH-1:0]   addend;
  logic [2*DATA_WIDTH-1:0]   acc_step;

  always_comb begin
    addend   = mplier_q[0] ? mcand_q : '0;
    acc_step = acc_q + addend;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    if (start) begin
      cnt_d    = CNT_LOAD;
      acc_d    = '0;
      mcand_d  = {{DATA_WIDTH{1'b0}}, a};
      mplier_d = b;
    end else if (cnt_q != '0) begin
      cnt_d    = cnt_q - CNT_ONE;
      acc_d    = acc_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

  assign busy      = (cnt_q != '0);
  assign last_step = (cnt_q == CNT_ONE);
  // Exposes the accumulator value including this cycle's step, so the final
  // product is available during last_step without an extra cycle.
  assign product   = acc_step;

endmodule

// File: rtl/param_seq_alu.sv
// Sequential multi-opcode ALU: opcode+A handshake, B on the following cycle,
// single-cycle logic/arithmetic ops and an iterative multiply.
module param_seq_alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int OPCODE_WIDTH = 3,
  parameter int MUL_ENABLE   = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    opcode_valid,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic [DATA_WIDTH-1:0]   data,
  output logic                    busy,
  output logic                    done,
  output logic [DATA_WIDTH-1:0]   result,
  output logic                    overflow,
  output logic                    error
);

  logic [1:0]              state_q, state_d;
  logic [OPCODE_WIDTH-1:0] op_q, op_d;
  logic [DATA_WIDTH-1:0]   a_q, a_d;
  logic [DATA_WIDTH-1:0]   result_q, result_d;
  logic                    overflow_q, overflow_d;
  logic                    error_q, error_d;

  logic [31:0]             op_ext;
  logic                    op_legal;
  logic                    op_is_mul;
  logic                    accept;
  logic [DATA_WIDTH:0]     sum_w;
  logic [DATA_WIDTH:0]     diff_w;
  logic [DATA_WIDTH-1:0]   alu_res;
  logic                    alu_ovf;

  logic                    mul_start;
  logic                    mul_busy;
  logic                    mul_last;
  logic [2*DATA_WIDTH-1:0] mul_product;

  alu_mul_seq #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mul (
    .clk       (clk),
    .reset     (reset),
    .start     (mul_start),
    .a         (a_q),
    .b         (data),
    .busy      (mul_busy),
    .last_step (mul_last),
    .product   (mul_product)
  );

  always_comb begin
    op_ext    = 32'(op_q);
    op_legal  = is_legal_op(op_ext, MUL_ENABLE != 0);
    op_is_mul = op_legal && (op_ext == OP_MUL);
    accept    = opcode_valid && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    mul_start = (state_q == ST_GET_B) && op_is_mul;

    // The extra top bit carries out of ADD and flags a borrow out of SUB.
    sum_w  = {1'b0, a_q} + {1'b0, data};
    diff_w = {1'b0, a_q} - {1'b0, data};

    alu_res = '0;
    alu_ovf = 1'b0;
    case (op_ext)
      OP_ADD: begin alu_res = sum_w[DATA_WIDTH-1:0];  alu_ovf = sum_w[DATA_WIDTH];  end
      OP_SUB: begin alu_res = diff_w[DATA_WIDTH-1:0]; alu_ovf = diff_w[DATA_WIDTH]; end
      OP_AND: alu_res = a_q & data;
      OP_OR:  alu_res = a_q | data;
      OP_XOR: alu_res = a_q ^ data;
      default: begin alu_res = '0; alu_ovf = 1'b0; end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    error_d    = error_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          op_d    = opcode;
          a_d     = data;
          state_d = ST_GET_B;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GET_B: begin
        if (op_is_mul) begin
          state_d = ST_MUL_RUN;
        end else begin
          result_d   = op_legal ? alu_res : '0;
          overflow_d = op_legal ? alu_ovf : 1'b0;
          error_d    = !op_legal;
          state_d    = ST_DONE;
        end
      end
      ST_MUL_RUN: begin
        if (mul_last) begin
          result_d   = mul_product[DATA_WIDTH-1:0];
          overflow_d = |mul_product[2*DATA_WIDTH-1:DATA_WIDTH];
          error_d    = 1'b0;
          state_d    = ST_DONE;
        end else if (!mul_busy) begin
          // Multiplier idle without having signalled its last step: recover
          // rather than wait forever.
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      a_q        <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
      error_q    <= error_d;
    end
  end

  assign busy     = (state_q == ST_GET_B) || (state_q == ST_MUL_RUN);
  assign done     = (state_q == ST_DONE);
  assign result   = result_q;
  assign overflow = overflow_q;
  assign error    = error_q;

endmodule

// File: tb/tb_param_seq_alu.sv
// Scoreboard bench for param_seq_alu: expectations queued at issue time,
// checked (value and cycle) when done pulses.
module tb_param_seq_alu;

  localparam int W = 8;

  typedef struct {
    logic [7:0] r;
    logic       o;
    logic       e;
    int         lat;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       opcode_valid;
  logic [2:0] opcode;
  logic [7:0] data;
  logic       busy, done, overflow, error;
  logic [7:0] result;

  logic       ov0;
  logic [2:0] op0;
  logic [7:0] d0;
  logic       busy0, done0, ovf0, err0;
  logic [7:0] res0;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  exp_t sb[$];
  logic [7:0] hold_r = '0;
  logic       hold_o = 1'b0;
  logic       hold_e = 1'b0;

  param_seq_alu #(.DATA_WIDTH(W), .OPCODE_WIDTH(3), .MUL_ENABLE(1)) dut (
    .clk(clk), .reset(reset), .opcode_valid(opcode_valid), .opcode(opcode), .data(data),
    .busy(busy), .done(done), .result(result), .overflow(overflow), .error(error)
  );

  param_seq_alu #(.DATA_WIDTH(W), .OPCODE_WIDTH(3), .MUL_ENABLE(0)) dut0 (
    .clk(clk), .reset(reset), .opcode_valid(ov0), .opcode(op0), .data(d0),
    .busy(busy0), .done(done0), .result(res0), .overflow(ovf0), .error(err0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                 input bit mul_en);
    exp_t m;
    logic [8:0]  s;
    logic [15:0] p;
    m.r = '0; m.o = 1'b0; m.e = 1'b0; m.lat = 2; m.cyc = 0;
    case (op)
      3'd0: begin s = {1'b0, a} + {1'b0, b}; m.r = s[7:0]; m.o = s[8]; end
      3'd1: begin m.r = a - b; m.o = (a < b); end
      3'd2: m.r = a & b;
      3'd3: m.r = a | b;
      3'd4: m.r = a ^ b;
      3'd5: begin
        if (mul_en) begin
          p = {8'h00, a} * {8'h00, b};
          m.r = p[7:0]; m.o = |p[15:8]; m.lat = W + 2;
        end else begin
          m.e = 1'b1;
        end
      end
      default: m.e = 1'b1;
    endcase
    return m;
  endfunction

  task automatic monitor_step();
    exp_t e;
    if (reset) begin
      hold_r = '0; hold_o = 1'b0; hold_e = 1'b0;
    end else if (done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", done, 0);
      end else begin
        e = sb.pop_front();
        chk("result", result, e.r);
        chk("overflow", overflow, e.o);
        chk("error", error, e.e);
        chk("done_cycle", cyc, e.cyc);
        hold_r = e.r; hold_o = e.o; hold_e = e.e;
      end
    end else begin
      chk("hold", {result, overflow, error}, {hold_r, hold_o, hold_e});
    end
  endtask

  always @(negedge clk) monitor_step();

  // Entered and left just after a rising edge; returns in cycle T+2.
  task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input bit push);
    exp_t m;
    m = model(op, a, b, 1'b1);
    m.cyc = cyc + m.lat;
    if (push) sb.push_back(m);
    opcode_valid = 1'b1; opcode = op; data = a;
    #1 chk("busy_T", busy, 0);
    @(posedge clk); #1;
    opcode_valid = 1'b0; opcode = 3'($urandom); data = b;
    #1 chk("busy_T1", busy, 1);
    @(posedge clk); #1;
    data = 8'($urandom);
    #1 chk("busy_T2", busy, (m.lat > 2) ? 1 : 0);
  endtask

  task automatic wait_sb();
    for (int k = 0; k < 40 && sb.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    chk("sb_drain", sb.size(), 0);
    sb.delete();
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; opcode_valid = 1'b0; opcode = '0; data = '0;
    ov0 = 1'b0; op0 = '0; d0 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_err", error, 0);
    reset = 1'b0;
    step();

    issue(3'd0, 8'hF0, 8'h20, 1); wait_sb();
    issue(3'd1, 8'h05, 8'h07, 1);
    issue(3'd2, 8'hCC, 8'h0F, 1); wait_sb();
    issue(3'd5, 8'h12, 8'h0D, 1); wait_sb();
    issue(3'd5, 8'h20, 8'h10, 1); wait_sb();

    // Opcode strobe during MUL_RUN must be ignored.
    issue(3'd5, 8'h3C, 8'h77, 1);
    repeat (2) step();
    opcode_valid = 1'b1; opcode = 3'd0; data = 8'h55;
    step();
    opcode_valid = 1'b0;
    wait_sb();

    issue(3'd7, 8'hFF, 8'h00, 1);
    issue(3'd0, 8'h01, 8'h01, 1); wait_sb();
    issue(3'd6, 8'hA5, 8'h5A, 1); wait_sb();
    issue(3'd4, 8'hA5, 8'hFF, 1); wait_sb();

    // Abort a multiply with reset in cycle T+5.
    issue(3'd5, 8'hFF, 8'hFF, 0);
    repeat (3) step();
    reset = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_result", result, 0);
    chk("abort_ovf", overflow, 0);
    chk("abort_err", error, 0);
    step();
    reset = 1'b0;
    repeat (12) step();
    issue(3'd0, 8'h7F, 8'h01, 1); wait_sb();

    for (int i = 0; i < 8; i++) begin
      issue(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1);
      wait_sb();
    end
    for (int i = 0; i < 5; i++) issue(3'($urandom_range(0, 4)), 8'($urandom), 8'($urandom), 1);
    wait_sb();

    // MUL_ENABLE=0 instance: MUL opcode is illegal, next legal op clears error.
    ov0 = 1'b1; op0 = 3'd5; d0 = 8'h12;
    step();
    ov0 = 1'b0; d0 = 8'h0D;
    step();
    chk("nomul_done", done0, 1);
    chk("nomul_err", err0, 1);
    chk("nomul_result", res0, 0);
    chk("nomul_ovf", ovf0, 0);
    ov0 = 1'b1; op0 = 3'd0; d0 = 8'h01;
    step();
    ov0 = 1'b0; d0 = 8'h02;
    step();
    chk("nomul_add_done", done0, 1);
    chk("nomul_add_err", err0, 0);
    chk("nomul_add_result", res0, 8'h03);

    repeat (3) step();
    chk("sb_final", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/param_seq_alu.md
Name: param_seq_alu

Overview:
Parametrised, multi-opcode successor to the team's 1-bit-opcode ALU. Operands arrive serially on a shared data bus after an opcode handshake. Single-cycle logic/arithmetic ops are supported, plus an iterative shift-add multiply. Adds a busy indication, illegal-opcode error reporting and full-width overflow, and drops into the existing test/checker top-level harness.

Parameters:
DATA_WIDTH, 8, operand/result width (>=2)
OPCODE_WIDTH, 3, opcode field width (>=3)
MUL_ENABLE, 1, 1 = MUL supported; 0 = MUL decodes as illegal

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
opcode_valid  input  1  opcode handshake strobe; data carries operand A in the same cycle
opcode  input  OPCODE_WIDTH  operation select, sampled when opcode_valid=1 and busy=0
data  input  DATA_WIDTH  operand A (opcode cycle), operand B (next cycle)
busy  output  1  1 while an operation is in progress; new opcodes are ignored
done  output  1  one-cycle pulse; result/overflow/error valid in this cycle
result  output  DATA_WIDTH  operation result, held until the next done
overflow  output  1  carry/borrow/high-half-nonzero flag, held with result
error  output  1  illegal opcode flag, held with result

Behaviour:
- Reset (async assert, sync release): state=IDLE; busy=0, done=0, result=0, overflow=0, error=0; mul counter/accumulator cleared. Reset mid-operation aborts it with no done pulse.
- Opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 MUL (if MUL_ENABLE), all other codes ILLEGAL. Upper opcode bits beyond 3 must be zero, or the code is ILLEGAL.
- FSM states: IDLE, GET_B, MUL_RUN, DONE.
  - IDLE/DONE + opcode_valid: latch opcode and A from data -> GET_B.
  - GET_B: latch B from data next cycle.
    - Non-MUL ops: compute and register the result -> DONE.
    - MUL: load the multiplier, counter=DATA_WIDTH -> MUL_RUN.
  - MUL_RUN: one shift-add step per cycle; counter decrements; at counter==1 register the result -> DONE.
  - DONE: done=1 for exactly one cycle -> IDLE, unless opcode_valid is accepted, in which case -> GET_B.
- busy=1 in GET_B and MUL_RUN; 0 in IDLE and DONE. opcode_valid while busy is ignored with no side effects. data is don't-care outside the A/B cycles.
- Latency, with opcode_valid in cycle T:
  - Non-MUL ops: done in cycle T+2.
  - MUL: done in cycle T+1+DATA_WIDTH+1 = T+DATA_WIDTH+2.
- Back-to-back: opcode_valid in a DONE cycle is accepted, giving a throughput of one non-MUL op every 2 cycles.
- Arithmetic (unsigned):
  - ADD: result = (A+B) mod 2^W; overflow = carry out.
  - SUB: result = (A-B) mod 2^W; overflow = borrow (A<B).
  - AND/OR/XOR: overflow=0.
  - MUL: 2W-bit product; result = low W bits; overflow = |high W bits.
- ILLEGAL: enter DONE directly from GET_B (done at T+2); result=0, overflow=0, error=1. error=0 for all legal ops.
- result/overflow/error update only at DONE entry and hold otherwise.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams (OP_ADD..OP_MUL)
  - FSM state encoding
  - helper function is_legal_op(opcode, MUL_ENABLE)
- Sub-module alu_mul_seq (DATA_WIDTH):
  - iterative shift-add multiplier
  - ports: start, a, b, busy, last_step, product[2W-1:0]
- The top-level FSM instantiates alu_mul_seq; the checker reuses alu_pkg.

Test Plan:
- Reset then ADD: op=000, A=0xF0, B=0x20 -> done at T+2, result=0x10, overflow=1, error=0, busy=1 only in T+1.
- SUB borrow, then back-to-back AND: SUB A=0x05, B=0x07 -> result=0xFE, overflow=1. AND issued in the DONE cycle, A=0xCC, B=0x0F -> result=0x0C, overflow=0 at T+4.
- MUL: A=0x12, B=0x0D -> done at T+10, result=0xEA, overflow=0. MUL A=0x20, B=0x10 -> result=0x00, overflow=1.
- opcode_valid=1 (op=000) during MUL_RUN -> ignored; MUL result unchanged; exactly one done pulse.
- Illegal op=111 with A=0xFF -> done at T+2, result=0x00, overflow=0, error=1. Next legal op clears error.
- reset asserted mid-MUL (cycle T+5) -> all outputs 0 immediately, no done. A new ADD after release completes normally. Repeat with MUL_ENABLE=0: op=101 -> error=1.
